// File: rtl/mmio_io_bridge_pkg.sv
// mmio_io_bridge_pkg
//   Shared definitions for the CPU I/O bridge: bus widths, I/O register
//   offsets inside the 16-word window, CTRL register bit positions and the
//   default debounce length.
package mmio_io_bridge_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 16;

    localparam logic [15:0] DEBOUNCE_CYC_DEFAULT = 16'd50000;

    // Register offsets within the I/O window (cpu_addr[3:0]).
    typedef enum logic [3:0] {
        IO_DISP = 4'd0,
        IO_CTRL = 4'd1,
        IO_SW   = 4'd2,
        IO_BTN  = 4'd3,
        IO_TICK = 4'd4
    } io_off_e;

    // CTRL register layout.
    localparam int unsigned CTRL_BLANK_BIT = 0;
    localparam int unsigned CTRL_LED_LSB   = 1;
    localparam int unsigned CTRL_LED_W     = 5;

    // TICK advances once every 2**TICK_DIV_W cycles.
    localparam int unsigned TICK_DIV_W = 10;

endpackage

// File: rtl/mmio_io_bridge_if.sv
// mmio_io_bridge_if
//   CPU data bus plus the RAM side signals that the bridge sits between.
//   master : CPU/RAM environment (drives store strobe, address, data, RAM data)
//   slave  : the bridge (returns load data, qualified RAM store strobe)
//   cpu_write_en  store strobe, one cycle per store
//   cpu_addr      word address
//   cpu_wdata     store data
//   cpu_rdata     load data, valid one cycle after cpu_addr
//   ram_write_en  RAM store strobe, suppressed for I/O window hits
//   ram_rdata     registered RAM read data (1-cycle latency)
interface mmio_io_bridge_if;
    import mmio_io_bridge_pkg::*;

    logic              cpu_write_en;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              ram_write_en;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output cpu_write_en, cpu_addr, cpu_wdata, ram_rdata,
        input  cpu_rdata, ram_write_en
    );

    modport slave (
        input  cpu_write_en, cpu_addr, cpu_wdata, ram_rdata,
        output cpu_rdata, ram_write_en
    );

endinterface

// File: rtl/mmio_io_bridge_input_debouncer.sv
// input_debouncer
//   One asynchronous input bit: 2-FF synchroniser followed by a debounce
//   counter. The debounced output only follows the synchronised input after
//   it has differed for DEBOUNCE_CYC consecutive cycles.
//   clk    system clock
//   reset  synchronous, active-high
//   raw    asynchronous input
//   deb    debounced output
module input_debouncer
    import mmio_io_bridge_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic deb
);

    logic        sync_a;
    logic        sync_b;
    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            cnt    <= '0;
            deb    <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            // Any cycle where the input agrees with the output restarts the
            // count, so a glitch shorter than DEBOUNCE_CYC never gets through.
            if (sync_b == deb) begin
                cnt <= '0;
            end else if (cnt == DEBOUNCE_CYC - 16'd1) begin
                deb <= sync_b;
                cnt <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/mmio_io_bridge.sv
// mmio_io_bridge
//   Decodes a 16-word I/O window at IO_BASE on the CPU data bus; every other
//   access passes through to the data RAM. Holds the display value, CTRL
//   (blank + LEDs), exposes debounced switches, sticky button events and a
//   free-running cycle/1024 tick counter. Loads from I/O and RAM share a
//   1-cycle latency.
//   clk, reset   system clock, synchronous active-high reset
//   bus          CPU/RAM bus (slave side)
//   sw_raw       asynchronous slide switches
//   btn_raw      asynchronous push buttons, 1 = pressed
//   disp_value   value for the four 7-segment digits
//   disp_blank   1 = all digits blanked
//   led_out      general LED register
module mmio_io_bridge
    import mmio_io_bridge_pkg::*;
#(
    parameter logic [9:0]  IO_BASE      = 10'h3F0,
    parameter logic [15:0] DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
    parameter int unsigned NUM_SW       = 8,
    parameter int unsigned NUM_BTN      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    mmio_io_bridge_if.slave       bus,
    input  logic [NUM_SW-1:0]     sw_raw,
    input  logic [NUM_BTN-1:0]    btn_raw,
    output logic [15:0]           disp_value,
    output logic                  disp_blank,
    output logic [CTRL_LED_W-1:0] led_out
);

    logic                  io_hit;
    logic                  io_wr;
    logic [3:0]            addr_q;
    logic                  io_hit_q;
    logic                  rd_valid;
    logic [TICK_DIV_W-1:0] tick_pre;
    logic [15:0]           tick_cnt;
    logic [NUM_SW-1:0]     sw_deb;
    logic [NUM_BTN-1:0]    btn_deb;
    logic [NUM_BTN-1:0]    btn_prev;
    logic [NUM_BTN-1:0]    btn_rise;
    logic [NUM_BTN-1:0]    btn_evt;
    logic                  btn_rd_clr;
    logic [15:0]           io_rdata;

    assign io_hit           = (bus.cpu_addr[9:4] == IO_BASE[9:4]);
    assign io_wr            = bus.cpu_write_en & io_hit;
    assign bus.ram_write_en = bus.cpu_write_en & ~io_hit;

    for (genvar i = 0; i < int'(NUM_SW); i++) begin : g_sw
        input_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (sw_raw[i]),
            .deb   (sw_deb[i])
        );
    end

    for (genvar i = 0; i < int'(NUM_BTN); i++) begin : g_btn
        input_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (btn_raw[i]),
            .deb   (btn_deb[i])
        );
    end

    // Writable registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_value <= '0;
            disp_blank <= 1'b0;
            led_out    <= '0;
        end else if (io_wr) begin
            if (bus.cpu_addr[3:0] == IO_DISP) begin
                disp_value <= bus.cpu_wdata;
            end else if (bus.cpu_addr[3:0] == IO_CTRL) begin
                disp_blank <= bus.cpu_wdata[CTRL_BLANK_BIT];
                led_out    <= bus.cpu_wdata[CTRL_LED_LSB +: CTRL_LED_W];
            end
        end
    end

    // Load address pipeline. rd_valid holds cpu_rdata at zero for the cycle
    // following a reset edge, whatever the RAM is presenting.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            io_hit_q <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            addr_q   <= bus.cpu_addr[3:0];
            io_hit_q <= io_hit;
            rd_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_pre <= '0;
            tick_cnt <= '0;
        end else begin
            tick_pre <= tick_pre + 1'b1;
            if (&tick_pre) begin
                tick_cnt <= tick_cnt + 16'd1;
            end
        end
    end

    assign btn_rise   = btn_deb & ~btn_prev;
    assign btn_rd_clr = rd_valid & io_hit_q & (addr_q == IO_BTN);

    // A BTN read returns every pending event, so the read clears them all;
    // an edge landing on the clearing cycle is OR-ed in afterwards and survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev <= '0;
            btn_evt  <= '0;
        end else begin
            btn_prev <= btn_deb;
            btn_evt  <= (btn_rd_clr ? '0 : btn_evt) | btn_rise;
        end
    end

    always_comb begin
        io_rdata = '0;
        case (addr_q)
            IO_DISP: io_rdata = disp_value;
            IO_CTRL: begin
                io_rdata[CTRL_BLANK_BIT]               = disp_blank;
                io_rdata[CTRL_LED_LSB +: CTRL_LED_W]   = led_out;
            end
            IO_SW:   io_rdata[NUM_SW-1:0]  = sw_deb;
            IO_BTN:  io_rdata[NUM_BTN-1:0] = btn_evt;
            IO_TICK: io_rdata = tick_cnt;
            default: io_rdata = '0;
        endcase
    end

    assign bus.cpu_rdata = !rd_valid ? '0 : (io_hit_q ? io_rdata : bus.ram_rdata);

endmodule

// File: tb/tb_mmio_io_bridge.sv
// tb_mmio_io_bridge
//   Directed plus randomized checks of mmio_io_bridge with DEBOUNCE_CYC=4,
//   against a behavioural model of the register map, RAM and tick counter.
module tb_mmio_io_bridge;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw_raw;
    logic [2:0] btn_raw;
    logic [15:0] disp_value;
    logic        disp_blank;
    logic [4:0]  led_out;

    always #5 clk = ~clk;

    mmio_io_bridge_if bus();

    mmio_io_bridge #(
        .IO_BASE      (10'h3F0),
        .DEBOUNCE_CYC (16'd4),
        .NUM_SW       (8),
        .NUM_BTN      (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .sw_raw     (sw_raw),
        .btn_raw    (btn_raw),
        .disp_value (disp_value),
        .disp_blank (disp_blank),
        .led_out    (led_out)
    );

    // Registered data RAM seen by the bridge.
    logic [15:0] ram_mem [1024];
    initial begin
        for (int i = 0; i < 1024; i++) ram_mem[i] = 16'($urandom);
    end
    always @(posedge clk) begin
        if (bus.ram_write_en) ram_mem[bus.cpu_addr] <= bus.cpu_wdata;
        bus.ram_rdata <= ram_mem[bus.cpu_addr];
    end

    // Edges since the last reset edge; TICK is this divided by 1024.
    int unsigned cyc;
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    // Reference model state.
    logic [15:0] disp_m;
    logic        blank_m;
    logic [4:0]  led_m;
    logic [15:0] ram_m [int];
    int          ram_addrs [$];

    int vectors = 0;
    int fails   = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [9:0] a, input logic [15:0] d);
        logic io;
        io = (a[9:4] == 6'h3F);
        bus.cpu_write_en = 1'b1;
        bus.cpu_addr     = a;
        bus.cpu_wdata    = d;
        #1;
        chk("ram_we", 16'(bus.ram_write_en), io ? 16'd0 : 16'd1);
        if (io) begin
            if (a[3:0] == 4'd0) disp_m = d;
            else if (a[3:0] == 4'd1) begin
                blank_m = d[0];
                led_m   = d[5:1];
            end
        end else begin
            ram_m[int'(a)] = d;
            ram_addrs.push_back(int'(a));
        end
        tick();
        bus.cpu_write_en = 1'b0;
        bus.cpu_addr     = '0;
        chk("disp", disp_value, disp_m);
        chk("blank", 16'(disp_blank), 16'(blank_m));
        chk("led", 16'(led_out), 16'(led_m));
    endtask

    task automatic load(input logic [9:0] a, input logic [15:0] exp, input string tag);
        bus.cpu_write_en = 1'b0;
        bus.cpu_addr     = a;
        tick();
        bus.cpu_addr     = '0;
        chk(tag, bus.cpu_rdata, exp);
    endtask

    task automatic load_tick();
        bus.cpu_write_en = 1'b0;
        bus.cpu_addr     = 10'h3F4;
        tick();
        bus.cpu_addr     = '0;
        chk("tick", bus.cpu_rdata, 16'(cyc / 1024));
    endtask

    initial begin
        logic [9:0]  a;
        logic [7:0]  swv;
        int unsigned idx;

        reset = 1'b1;
        bus.cpu_write_en = 1'b0;
        bus.cpu_addr     = '0;
        bus.cpu_wdata    = '0;
        sw_raw  = '0;
        btn_raw = '0;
        disp_m  = '0;
        blank_m = 1'b0;
        led_m   = '0;

        repeat (3) tick();
        chk("reset_rdata", bus.cpu_rdata, 16'h0000);
        chk("reset_disp", disp_value, 16'h0000);
        chk("reset_blank", 16'(disp_blank), 16'd0);
        chk("reset_led", 16'(led_out), 16'd0);
        reset = 1'b0;
        load(10'h3F2, 16'h0000, "sw_after_reset");

        store(10'h3F0, 16'hBEEF);
        load(10'h3F0, 16'hBEEF, "disp_rd");
        store(10'h010, 16'h1234);
        load(10'h010, 16'h1234, "ram_rd");

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 6))
                0: store(10'h3F0, 16'($urandom));
                1: store(10'h3F1, 16'($urandom));
                2: store(10'(10'h3F5 + $urandom_range(0, 10)), 16'($urandom));
                3: store(10'($urandom_range(0, 32'h3EF)), 16'($urandom));
                4: begin
                    load(10'h3F0, disp_m, "rand_disp");
                    load(10'h3F1, {10'b0, led_m, blank_m}, "rand_ctrl");
                end
                5: begin
                    idx = $urandom_range(0, ram_addrs.size() - 1);
                    a = 10'(ram_addrs[idx]);
                    load(a, ram_m[int'(a)], "rand_ram");
                end
                default: begin
                    load(10'(10'h3F5 + $urandom_range(0, 10)), 16'h0000, "rand_unmapped");
                    load_tick();
                end
            endcase
        end

        store(10'h3F1, 16'h003F);
        chk("ctrl_blank", 16'(disp_blank), 16'd1);
        chk("ctrl_led", 16'(led_out), 16'h001F);
        store(10'h3F9, 16'hFFFF);
        load(10'h3F9, 16'h0000, "unmapped_rd");
        load(10'h3F1, 16'h003F, "ctrl_rd");

        sw_raw = 8'h01;
        repeat (2) tick();
        sw_raw = 8'h00;
        repeat (10) tick();
        load(10'h3F2, 16'h0000, "sw_glitch");
        sw_raw = 8'h01;
        repeat (10) tick();
        load(10'h3F2, 16'h0001, "sw_hold");
        repeat (4) begin
            swv = 8'($urandom);
            sw_raw = swv;
            repeat (10) tick();
            load(10'h3F2, {8'h00, swv}, "sw_rand");
        end
        sw_raw = 8'h00;
        repeat (10) tick();

        btn_raw = 3'b010;
        repeat (8) tick();
        btn_raw = 3'b000;
        repeat (8) tick();
        load(10'h3F3, 16'h0002, "btn_sticky");
        load(10'h3F3, 16'h0000, "btn_clear");

        // btn[0]'s debounced edge lands on the same cycle the first BTN read clears.
        btn_raw = 3'b010;
        repeat (8) tick();
        btn_raw = 3'b000;
        repeat (8) tick();
        btn_raw = 3'b001;
        repeat (5) tick();
        load(10'h3F3, 16'h0002, "btn_coinc_rd");
        load(10'h3F3, 16'h0001, "btn_coinc_keep");
        btn_raw = 3'b000;
        repeat (8) tick();
        load(10'h3F3, 16'h0000, "btn_release");

        repeat (1100) tick();
        load_tick();

        store(10'h3F0, 16'hA5A5);
        sw_raw = 8'h80;
        repeat (3) tick();
        bus.cpu_addr = 10'h3F0;
        reset = 1'b1;
        tick();
        chk("reset_during_load", bus.cpu_rdata, 16'h0000);
        bus.cpu_addr = '0;
        reset = 1'b0;
        disp_m  = '0;
        blank_m = 1'b0;
        led_m   = '0;
        chk("reset_disp2", disp_value, 16'h0000);
        repeat (2) tick();
        load(10'h3F2, 16'h0000, "sw_reset_discard");
        repeat (10) tick();
        load(10'h3F2, 16'h0080, "sw_after_rst");
        load_tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
